twofish_seq_counters: RTL



---
 rtl/twofish_seq_counters.sv | 72 +++++++
 1 files changed

// File: rtl/twofish_seq_counters.sv
// Round and key-schedule down-counter pair for the Twofish sequencer.
// Exposes zero flags, done pulses and the derived round/subkey addresses.
module twofish_seq_counters #(
    parameter int ROUNDS = 16,
    parameter int KSTEPS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       srst,
    input  logic       sce,
    input  logic       krst,
    input  logic       kce,
    output logic       szero,
    output logic       kzero,
    output logic [5:0] round_idx,
    output logic [6:0] rk_addr,
    output logic [5:0] ks_addr,
    output logic       sdone,
    output logic       kdone
);

    localparam logic [5:0] ROUNDS_LOAD = 6'(ROUNDS);
    localparam logic [5:0] KSTEPS_LOAD = 6'(KSTEPS);
    localparam logic [6:0] ROUNDS_EXT  = 7'(ROUNDS);
    localparam logic [6:0] KSTEPS_EXT  = 7'(KSTEPS);

    logic [5:0] scnt;
    logic [5:0] kcnt;
    logic       sfinal;
    logic       kfinal;

    // A decrement from 1 is the only way to reach 0 with a done pulse.
    assign sfinal = sce && !srst && (scnt == 6'd1);
    assign kfinal = kce && !krst && (kcnt == 6'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scnt  <= 6'd0;
            sdone <= 1'b0;
        end else begin
            sdone <= sfinal;
            if (srst) begin
                scnt <= ROUNDS_LOAD;
            end else if (sce && (scnt != 6'd0)) begin
                scnt <= scnt - 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kcnt  <= 6'd0;
            kdone <= 1'b0;
        end else begin
            kdone <= kfinal;
            if (krst) begin
                kcnt <= KSTEPS_LOAD;
            end else if (kce && (kcnt != 6'd0)) begin
                kcnt <= kcnt - 6'd1;
            end
        end
    end

    assign szero = (scnt == 6'd0);
    assign kzero = (kcnt == 6'd0);

    // Addresses still follow the formula at zero; consumers gate them with the flags.
    assign round_idx = 6'(ROUNDS_EXT - {1'b0, scnt});
    assign rk_addr   = 7'd8 + {round_idx, 1'b0};
    assign ks_addr   = 6'({KSTEPS_EXT - {1'b0, kcnt}, 1'b0});

endmodule
